// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: operators, FSM states and
// the request priority encoder.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_LOAD,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_RUN,
        ST_DIV_RUN,
        ST_FIX
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_CLEAR,
        REQ_EQUALS,
        REQ_ADD,
        REQ_SUB,
        REQ_MUL,
        REQ_DIV
    } req_e;

    localparam int unsigned NREQ      = 6;
    localparam int unsigned RB_CLEAR  = 0;
    localparam int unsigned RB_EQUALS = 1;
    localparam int unsigned RB_ADD    = 2;
    localparam int unsigned RB_SUB    = 3;
    localparam int unsigned RB_MUL    = 4;
    localparam int unsigned RB_DIV    = 5;

    // Highest-priority request edge wins; all others in the cycle are dropped.
    function automatic req_e prio_req(input logic [NREQ-1:0] e);
        if (e[RB_CLEAR])  return REQ_CLEAR;
        if (e[RB_EQUALS]) return REQ_EQUALS;
        if (e[RB_ADD])    return REQ_ADD;
        if (e[RB_SUB])    return REQ_SUB;
        if (e[RB_MUL])    return REQ_MUL;
        if (e[RB_DIV])    return REQ_DIV;
        return REQ_NONE;
    endfunction

    // Operator left pending after a request; equals returns to LOAD.
    function automatic op_e req_to_op(input req_e r);
        case (r)
            REQ_ADD: return OP_ADD;
            REQ_SUB: return OP_SUB;
            REQ_MUL: return OP_MUL;
            REQ_DIV: return OP_DIV;
            default: return OP_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative sign-magnitude multiply (shift-add) and restoring divide with a
// final FIX cycle that applies the sign and range-checks the result.
module seq_muldiv
    import calc_pkg::*;
#(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  op_e          op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_c,
    output logic [W-1:0] q_c,
    output logic         ovf_c
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [2*W-1:0] MIN_MAG = (2*W)'(1) << (W - 1);

    state_e         state_q, state_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] work_q, work_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic           neg_q, neg_d;
    logic           is_div_q, is_div_d;

    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     mul_sum, div_diff;
    logic [2*W-1:0] res_mag;
    logic           fits;

    assign a_mag = a_i[W-1] ? W'(-a_i) : a_i;
    assign b_mag = b_i[W-1] ? W'(-b_i) : b_i;

    // Upper half accumulates the multiplicand; for divide, {rem, quotient msb} minus divisor.
    assign mul_sum  = {1'b0, work_q[2*W-1:W]} + {1'b0, (work_q[0] ? opnd_q : W'(0))};
    assign div_diff = work_q[2*W-1:W-1] - {1'b0, opnd_q};

    assign res_mag = is_div_q ? {W'(0), work_q[W-1:0]} : work_q;
    assign fits    = (res_mag[2*W-1:W-1] == '0) || (neg_q && (res_mag == MIN_MAG));
    assign busy_o  = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            is_div_q <= is_div_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        is_div_d = is_div_q;
        done_c   = 1'b0;
        q_c      = '0;
        ovf_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    neg_d    = a_i[W-1] ^ b_i[W-1];
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    is_div_d = (op_i == OP_DIV);
                    if (op_i == OP_DIV) begin
                        opnd_d  = b_mag;
                        work_d  = {W'(0), a_mag};
                        state_d = ST_DIV_RUN;
                    end else begin
                        opnd_d  = a_mag;
                        work_d  = {W'(0), b_mag};
                        state_d = ST_MUL_RUN;
                    end
                end
            end
            ST_MUL_RUN: begin
                work_d = {mul_sum, work_q[W-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = ST_FIX;
            end
            ST_DIV_RUN: begin
                work_d = div_diff[W] ? {work_q[2*W-2:0], 1'b0}
                                     : {div_diff[W-1:0], work_q[W-2:0], 1'b1};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                done_c  = 1'b1;
                ovf_c   = (is_div_q && (opnd_q == '0)) || !fits;
                q_c     = neg_q ? W'(-res_mag[W-1:0]) : res_mag[W-1:0];
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops any in-flight operation without a completion.
        if (abort_i) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_c  = 1'b0;
        end
    end

endmodule

// File: rtl/seq_calc_core.sv
// Four-function calculator core: request edge detection and priority,
// signed accumulator with pending operator, sticky overflow.
module seq_calc_core
    import calc_pkg::*;
#(
    parameter int unsigned W = 11
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                clear,
    input  logic                equals,
    input  logic                add,
    input  logic                sub,
    input  logic                mult,
    input  logic                div,
    input  logic signed [W-1:0] operand,
    output logic signed [W-1:0] result,
    output logic                overflow,
    output logic                busy,
    output logic                done
);

    logic [NREQ-1:0]     req_now, req_q, edges;
    req_e                kind;
    op_e                 nxt_op;
    logic signed [W-1:0] acc_q, acc_d;
    op_e                 pend_q, pend_d;
    op_e                 pend_nxt_q, pend_nxt_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic signed [W-1:0] sum_c, dif_c;
    logic                add_ovf_c, sub_ovf_c;
    logic                start_c, abort_c;
    logic                md_busy, md_done_c, md_ovf_c;
    logic [W-1:0]        md_q_c;

    assign req_now = {div, mult, sub, add, equals, clear};
    assign edges   = req_now & ~req_q;
    assign kind    = prio_req(edges);
    assign nxt_op  = req_to_op(kind);

    assign sum_c     = acc_q + operand;
    assign dif_c     = acc_q - operand;
    assign add_ovf_c = (acc_q[W-1] == operand[W-1]) && (sum_c[W-1] != acc_q[W-1]);
    assign sub_ovf_c = (acc_q[W-1] != operand[W-1]) && (dif_c[W-1] != acc_q[W-1]);

    assign result   = acc_q;
    assign overflow = ovf_q;
    assign busy     = md_busy;
    assign done     = done_q;

    seq_muldiv #(.W(W)) u_muldiv (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .start_i (start_c),
        .abort_i (abort_c),
        .op_i    (pend_q),
        .a_i     (acc_q),
        .b_i     (operand),
        .busy_o  (md_busy),
        .done_c  (md_done_c),
        .q_c     (md_q_c),
        .ovf_c   (md_ovf_c)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            req_q      <= '0;
            acc_q      <= '0;
            pend_q     <= OP_LOAD;
            pend_nxt_q <= OP_LOAD;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            req_q      <= req_now;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            pend_nxt_q <= pend_nxt_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Clear always wins; a finishing mul/div excludes new edges since busy is still high.
    always_comb begin
        acc_d      = acc_q;
        pend_d     = pend_q;
        pend_nxt_d = pend_nxt_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        start_c    = 1'b0;
        abort_c    = 1'b0;

        if (kind == REQ_CLEAR) begin
            acc_d   = '0;
            pend_d  = OP_LOAD;
            ovf_d   = 1'b0;
            abort_c = 1'b1;
        end else if (md_done_c) begin
            done_d = 1'b1;
            if (md_ovf_c) begin
                ovf_d  = 1'b1;
                pend_d = OP_LOAD;
            end else begin
                acc_d  = md_q_c;
                pend_d = pend_nxt_q;
            end
        end else if ((kind != REQ_NONE) && !md_busy && !ovf_q) begin
            case (pend_q)
                OP_LOAD: begin
                    acc_d  = operand;
                    pend_d = nxt_op;
                    done_d = 1'b1;
                end
                OP_ADD: begin
                    done_d = 1'b1;
                    if (add_ovf_c) begin
                        ovf_d  = 1'b1;
                        pend_d = OP_LOAD;
                    end else begin
                        acc_d  = sum_c;
                        pend_d = nxt_op;
                    end
                end
                OP_SUB: begin
                    done_d = 1'b1;
                    if (sub_ovf_c) begin
                        ovf_d  = 1'b1;
                        pend_d = OP_LOAD;
                    end else begin
                        acc_d  = dif_c;
                        pend_d = nxt_op;
                    end
                end
                default: begin
                    start_c    = 1'b1;
                    pend_nxt_d = nxt_op;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc_core.sv
// Scoreboard bench for seq_calc_core (W=11): expected results are queued as
// requests are issued and checked on every done pulse.
module tb_seq_calc_core;

    localparam int W = 11;
    localparam logic [5:0] M_CLR = 6'b000001;
    localparam logic [5:0] M_EQ  = 6'b000010;
    localparam logic [5:0] M_ADD = 6'b000100;
    localparam logic [5:0] M_SUB = 6'b001000;
    localparam logic [5:0] M_MUL = 6'b010000;
    localparam logic [5:0] M_DIV = 6'b100000;

    typedef struct {
        logic signed [W-1:0] res;
        logic                ovf;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                clear, equals, add, sub, mult, div;
    logic signed [W-1:0] operand;
    logic signed [W-1:0] result;
    logic                overflow, busy, done;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   done_seen;
    int   bc;
    int   ds0;

    seq_calc_core #(.W(W)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .clear    (clear),
        .equals   (equals),
        .add      (add),
        .sub      (sub),
        .mult     (mult),
        .div      (div),
        .operand  (operand),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic o);
        exp_t e;
        e.res = W'(r);
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic set_reqs(input logic [5:0] m);
        clear  = m[0];
        equals = m[1];
        add    = m[2];
        sub    = m[3];
        mult   = m[4];
        div    = m[5];
    endtask

    // Pulse requests for one cycle, then wait out any busy period.
    task automatic do_req(input logic [5:0] m, input int val, output int busy_cycles);
        @(negedge clk);
        operand = W'(val);
        set_reqs(m);
        @(negedge clk);
        set_reqs(6'b0);
        busy_cycles = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (busy_cycles >= 40) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout got busy after %0d cycles expected idle", busy_cycles);
        end
        @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got result %0d overflow %0d expected no done",
                             result, overflow);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_result", int'(result), int'(e.res));
                    chk("done_overflow", int'(overflow), int'(e.ovf));
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        operand   = '0;
        set_reqs(6'b0);
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_result", int'(result), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // Held add acts exactly once.
        ds0     = done_seen;
        operand = 11'sd5;
        add     = 1'b1;
        push(5, 1'b0);
        rst_n   = 1'b1;
        repeat (50) @(negedge clk);
        add = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_add_result", int'(result), 5);
        chk("hold_add_done_count", done_seen - ds0, 1);

        do_req(M_CLR, 0, bc);
        chk("clear_result", int'(result), 0);

        push(25, 1'b0);  do_req(M_ADD, 25, bc);
        push(42, 1'b0);  do_req(M_EQ, 17, bc);
        chk("add_eq_result", int'(result), 42);

        push(-12, 1'b0); do_req(M_MUL, -12, bc);
        push(-84, 1'b0); do_req(M_EQ, 7, bc);
        chk("mul_busy_cycles", bc, 12);

        push(-100, 1'b0); do_req(M_MUL, -100, bc);
        push(-100, 1'b1); do_req(M_EQ, 11, bc);
        chk("mul_ovf_flag", int'(overflow), 1);
        do_req(M_CLR, 0, bc);
        chk("clear_ovf", int'(overflow), 0);

        push(-100, 1'b0); do_req(M_DIV, -100, bc);
        push(-14, 1'b0);  do_req(M_EQ, 7, bc);
        chk("div_busy_cycles", bc, 12);
        push(-14, 1'b0);  do_req(M_DIV, -14, bc);
        push(-14, 1'b1);  do_req(M_EQ, 0, bc);
        do_req(M_ADD, 3, bc);
        chk("ignored_add_result", int'(result), -14);
        chk("ignored_add_ovf", int'(overflow), 1);
        do_req(M_CLR, 0, bc);
        chk("clear2_result", int'(result), 0);
        chk("clear2_ovf", int'(overflow), 0);

        push(1000, 1'b0); do_req(M_ADD, 1000, bc);
        push(1000, 1'b1); do_req(M_EQ, 100, bc);
        do_req(M_CLR, 0, bc);
        push(-1024, 1'b0); do_req(M_DIV, -1024, bc);
        push(-1024, 1'b1); do_req(M_EQ, -1, bc);
        do_req(M_CLR, 0, bc);

        // Product exactly at the negative limit is representable.
        push(-32, 1'b0);   do_req(M_MUL, -32, bc);
        push(-1024, 1'b0); do_req(M_EQ, 32, bc);

        // Same-cycle priority: add over mult, equals over sub, clear over add.
        push(9, 1'b0);  do_req(M_ADD | M_MUL, 9, bc);
        push(10, 1'b0); do_req(M_EQ | M_SUB, 1, bc);
        push(4, 1'b0);  do_req(M_SUB, 4, bc);
        push(-6, 1'b0); do_req(M_EQ, 10, bc);
        do_req(M_CLR | M_ADD, 77, bc);
        chk("clear_prio_result", int'(result), 0);

        // Clear four cycles into a multiply.
        push(6, 1'b0); do_req(M_MUL, 6, bc);
        @(negedge clk);
        operand = 11'sd7;
        equals  = 1'b1;
        @(negedge clk);
        equals = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_ovf", int'(overflow), 0);
        repeat (20) @(negedge clk);

        // Reset in the middle of a divide.
        push(50, 1'b0); do_req(M_DIV, 50, bc);
        @(negedge clk);
        operand = 11'sd7;
        equals  = 1'b1;
        @(negedge clk);
        equals = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_result", int'(result), 0);
        chk("midreset_ovf", int'(overflow), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        chk("pending_expectations", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_calc_core.md
# seq_calc_core

Parametrised sequential four-function calculator core: a signed accumulator with a pending-operator model, hardware rising-edge detection on the operation requests, and multi-cycle shift-add multiply and restoring divide with a busy/done handshake. It sits between the board-level button/switch decoding and the 7-segment display encoders. Width is generic, so the same core serves the 11-bit board build and wider simulation builds.

## Interface
- W, 11: operand and result width, signed two's complement, W >= 4.
- CLOCK_50  in  1  system clock; all state on its rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- clear  in  1  level request: zero accumulator, drop overflow.
- equals  in  1  level request: apply pending operator.
- add, sub, mult, div  in  1 each  level operator requests.
- operand  in  W  signed operand, sampled in the cycle a request edge is accepted.
- result  out  W  signed accumulator value.
- overflow  out  1  sticky error flag.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse when any operation commits.

## Operation
- Edge detect: each request is registered every cycle; an edge is `req & ~req_q`. A held request acts once.
- Priority within one cycle: clear > equals > add > sub > mult > div. Lower-priority edges in that cycle are discarded.
- State: accumulator `acc`, pending operator `pend` (LOAD, ADD, SUB, MUL, DIV), `overflow`.
- Operator edge (add/sub/mult/div): `acc <= acc pend operand`, then `pend <=` the new operator. With `pend = LOAD`, `acc <= operand`.
- equals edge: `acc <= acc pend operand`, then `pend <= LOAD`.
- clear edge: `acc <= 0`, `pend <= LOAD`, `overflow <= 0`. Clear is accepted in any state and aborts an in-flight multiply or divide without a done pulse.
- Arithmetic:
  - ADD/SUB: W-bit signed. Overflow when the operand signs agree (ADD) or differ (SUB) and the result sign differs from `acc`.
  - MUL: magnitudes are multiplied over W shift-add iterations into a 2W-bit product, then the sign is applied. Overflow when the product is not representable in W signed bits.
  - DIV: W-iteration restoring divide on magnitudes; the quotient truncates toward zero and the remainder is discarded. Overflow on divisor 0, or on -2^(W-1) / -1.
- On overflow: `acc` is held at its pre-operation value, `overflow` is set and `pend` is set to LOAD. While overflow=1, every edge except clear is ignored.
- Any non-clear edge while busy=1 is ignored.
- FSM states:
  - IDLE: go to MUL_RUN or DIV_RUN when the applied operator is MUL or DIV; otherwise commit in place.
  - MUL_RUN and DIV_RUN: run W iterations, then go to FIX.
  - FIX: apply the sign, check overflow, commit, return to IDLE.
- Reset values: result=0, overflow=0, busy=0, done=0, `pend`=LOAD, FSM=IDLE, all edge registers=0.

## Timing
- An edge is detected in cycle t.
- LOAD/ADD/SUB commit: result and overflow update at the clock edge ending cycle t; done is high in cycle t+1.
- MUL/DIV:
  - busy is high from cycle t+1 through t+W+1.
  - result updates at the end of cycle t+W+1.
  - done is high in cycle t+W+2, and busy is 0 in that cycle.
- Operand and `pend` are captured at edge t. The operand input may change freely afterwards.
- A new request edge is accepted in the same cycle that done is high.
- When RESET_N is asserted mid-operation, the block returns to reset values immediately; no done pulse is produced.

## Structure
- Package `calc_pkg`: operator enum (OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_DIV), FSM state enum, and the request-priority encoding function.
- Sub-module `seq_muldiv`, parameter W:
  - Inputs: start, op (MUL/DIV), a, b.
  - Outputs: busy, done, q (W bits), ovf.
  - Contains the iterative datapath and the FIX step.
- The top of `seq_calc_core` holds the edge detectors, priority, accumulator, pending operator and overflow logic.

## Test plan
All scenarios use W=11 (range -1024..1023).
- Reset: with RESET_N low, result=0, overflow=0, busy=0. Hold add high for 50 cycles after release with operand=5 -> exactly one action, result=5, one done pulse.
- clear; operand=25, add; operand=17, equals -> result=42 one cycle after the equals edge, overflow=0.
- operand=-12, mult; operand=7, equals -> busy high for 12 cycles, then result=-84 and a single done pulse. Repeat with operand=-100 mult 11 -> overflow=1, result holds -100.
- operand=-100, div; operand=7, equals -> result=-14. Then operand=0, div, equals -> overflow=1, result=-14. A following add edge is ignored; clear -> result=0, overflow=0.
- Overflow cases: 1000 add 100 equals -> overflow=1, result=1000. -1024 div -1 equals -> overflow=1.
- Aborts:
  - Clear asserted 4 cycles into a multiply -> busy=0 next cycle, result=0, no done.
  - RESET_N pulsed mid-divide -> all outputs at reset values.
